regfile_wb_sched: RTL

//  Write-back scheduler and scoreboard for the 32x32 register file.
//  - Shares the regfile's single write port (we/wa/wd) between two producers: ALU and memory/load.
//  - Tracks which registers have a write outstanding and tells the issue stage to stall on RAW/WAW hazards.
//  - Sits between the execute/memory stages and the register file; drives the regfile's we, wa and wd inputs.

---
 rtl/regfile_wb_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched
//   Write-back scheduler and scoreboard for the 32x32 register file.
//   Two producers (ALU, load) share the regfile's single write port through a
//   round-robin arbiter. A busy vector tracks outstanding writes, and the
//   issue stage is told to stall on RAW/WAW hazards.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   alu_valid/ready/wa/wd ALU write-back request channel
//   mem_valid/ready/wa/wd load write-back request channel
//   rsv_valid, rsv_wa     issue stage reserves a destination register
//   ra0, ra1              issue-stage source registers
//   stall                 issue must hold; the reservation is not taken
//   rf_we, rf_wa, rf_wd   regfile write port (registered, 1-cycle latency)
//   fwd0, fwd1, fwd_wd    write-port bypass to the issue stage
//                         (RF_WB_FWD_EN builds only)
//   busy                  scoreboard; bit i = write to register i outstanding
//
// Configuration
//   RF_WB_FWD_EN  when defined, adds the fwd0/fwd1/fwd_wd bypass and lets a
//                 source that is being written this cycle skip its stall.
//
// Handshake: a transfer happens when valid & ready. Requesters hold valid,
// wa and wd stable until ready. ready is combinational from both valids and
// the round-robin pointer, and is never asserted without valid.
// -----------------------------------------------------------------------------
module regfile_wb_sched #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_wa,
  input  logic [DW-1:0]   alu_wd,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_wa,
  input  logic [DW-1:0]   mem_wd,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_wa,
  input  logic [AW-1:0]   ra0,
  input  logic [AW-1:0]   ra1,
  output logic            stall,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [DW-1:0]   rf_wd,
`ifdef RF_WB_FWD_EN
  output logic            fwd0,
  output logic            fwd1,
  output logic [DW-1:0]   fwd_wd,
`endif
  output logic [NREG-1:0] busy
);

  // rr_q = 0: ALU wins a contended cycle; 1: load wins.
  logic            rr_q,    rr_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_wa_q, rf_wa_d;
  logic [DW-1:0]   rf_wd_q, rf_wd_d;
  logic [NREG-1:0] busy_q,  busy_d;

  logic            grant;
  logic [AW-1:0]   g_wa;
  logic [DW-1:0]   g_wd;
  logic            hz0, hz1, hzw;
  logic            rsv_take;
  logic            f0, f1;

  always_comb begin
    // Arbitration
    alu_ready = alu_valid & (~mem_valid | ~rr_q);
    mem_ready = mem_valid & (~alu_valid | rr_q);
    grant     = alu_ready | mem_ready;
    g_wa      = alu_ready ? alu_wa : mem_wa;
    g_wd      = alu_ready ? alu_wd : mem_wd;

    // After a contended grant the pointer moves to the loser.
    rr_d = rr_q;
    if (alu_valid & mem_valid) rr_d = ~rr_q;

    // Write stage: x0 writes are accepted but never reach the regfile.
    rf_we_d = grant & (g_wa != '0);
    rf_wa_d = rf_we_d ? g_wa : rf_wa_q;
    rf_wd_d = rf_we_d ? g_wd : rf_wd_q;

    // Bypass of the write currently on the regfile port.
`ifdef RF_WB_FWD_EN
    f0 = rf_we_q & (rf_wa_q == ra0) & (ra0 != '0);
    f1 = rf_we_q & (rf_wa_q == ra1) & (ra1 != '0);
`else
    f0 = 1'b0;
    f1 = 1'b0;
`endif

    // Hazard check; busy_q[0] is held at 0, so x0 never stalls.
    hz0      = busy_q[ra0] & ~f0;
    hz1      = busy_q[ra1] & ~f1;
    hzw      = busy_q[rsv_wa];
    stall    = rsv_valid & (hz0 | hz1 | hzw);
    rsv_take = rsv_valid & ~stall & (rsv_wa != '0);

    // Clear on write-back first, then set, so a same-cycle set wins.
    busy_d = busy_q;
    if (rf_we_q)  busy_d[rf_wa_q] = 1'b0;
    if (rsv_take) busy_d[rsv_wa]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= 1'b0;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
      busy_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;
  assign busy  = busy_q;

`ifdef RF_WB_FWD_EN
  assign fwd0   = f0;
  assign fwd1   = f1;
  assign fwd_wd = rf_wd_q;
`endif

endmodule
